pmp_checker: RTL and testbench
==============================

Name: pmp_checker

Overview:
- RISC-V Physical Memory Protection checker for a 64-bit core with up to 16 PMP entries.
- Each cycle it evaluates one address and access type (read, write or execute) against the pmpcfg and pmpaddr CSR contents and the current privilege.
- It returns a registered ok (access permitted) one cycle later.
- It sits beside the MMU/LSU and fetch path; the CSRs are owned elsewhere and arrive as flat inputs.

Parameters:
- pmp_check, 1: PMP enabled; 0 means ok = 1 always (after reset).
- pmp_no_tor, 0: 1 means TOR mode is treated as OFF.
- pmp_entries, 16: implemented entries, 0..16. Entries at or above pmp_entries never match.
- pmp_g, 10: granularity G; the minimum region is 2^(G+2) bytes.
- pmp_msb, 55: MSB of the physical address. pmpaddrbits = pmp_msb-1 = 54.

Ports:
- clk300p  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pmpaddr  in  pmp_entries x (pmpaddrbits+1)  pmpaddr CSRs (address bits [pmp_msb:2]). The top carry bit is ignored.
- pmpcfg0  in  64  cfg bytes for entries 0-7.
- pmpcfg2  in  64  cfg bytes for entries 8-15.
- address  in  pmp_msb+1  physical byte address.
- acc  in  2  access type: 00 = X, 01 = R, 11 = W (10 is treated as R).
- prv  in  2  current privilege: 11 = M, 01 = S, 00 = U.
- mprv  in  1  mstatus.MPRV.
- mpp  in  2  mstatus.MPP.
- valid  in  1  access request qualifier.
- ok  out  1  registered grant.

Behaviour:
- Cfg byte layout, per entry i (byte i of cfg0, or byte i-8 of cfg2):
  - bit0 = R, bit1 = W, bit2 = X
  - bits[4:3] = A: 00 OFF, 01 TOR, 10 NA4, 11 NAPOT
  - bit7 = L
- Effective privilege: if mprv=1 and prv=M and acc!=X, use mpp; otherwise use prv.
- Matching uses a = address[pmp_msb:2] and p = pmpaddr[i][pmpaddrbits-1:0].
  - OFF: no match.
  - TOR: match when p[i-1] <= a < p[i]. Compare only bits [pmpaddrbits-1:G]. Entry 0 uses a lower bound of 0. If p[i-1] >= p[i], there is no match.
  - NAPOT: when G >= 2, force p[G-2:0] to ones. Let k = index of the lowest zero bit of p. Match when a and p agree on bits above k.
  - NA4: exact match a == p when G = 0. When G >= 1, treat as NAPOT.
- Priority: the lowest-index matching entry wins. Later entries are ignored.
- Permission selection: acc X uses the X bit, W uses the W bit, R uses the R bit.
- Decision when an entry matches:
  - L=1: grant = permission bit, for every privilege including M.
  - L=0: grant = 1 if effective privilege is M; otherwise grant = permission bit.
- Decision when no entry matches: grant = 1 if effective privilege is M; otherwise grant = 0.
- ok update at the next rising edge: ok <= (!valid) | grant. Latency is exactly 1 cycle, with no stall or backpressure.
- Reset: ok = 0 while rst is asserted. The first valid result appears on the edge after rst deasserts.
- CSR and address inputs may change every cycle. There is no internal state other than the ok register.

Decomposition:
- pmp_pkg holds:
  - word64
  - pmpaddrbits constant
  - pmpaddr_type (pmpaddrbits+1 bits)
  - pmpaddr_vec_type (array of 16)
  - A-mode and privilege encodings
- One sub-module, pmp_entry_match, is generated per entry. It takes address, p[i], p[i-1] and the cfg byte, and produces a match flag and the R/W/X/L bits.
- A priority encoder at the top level selects the winning entry.

Test Plan:
- NAPOT read, U mode:
  - pmpaddr[0] = 0x2000_03FF (region 0x8000_0000..0x8000_1FFF), pmpcfg0[7:0] = 0x1B.
  - prv=U, acc=R, addr 0x8000_1000, valid=1 -> ok=1 next cycle.
  - Same with acc=X -> ok=0.
- Unmatched address, same setup, addr 0x8000_2000:
  - prv=U, valid=1 -> ok=0.
  - prv=M, mprv=0 -> ok=1.
  - valid=0 with prv=U -> ok=1.
- Lock:
  - pmpcfg0[7:0] = 0x98 (L, NAPOT, no permissions).
  - prv=M, acc=R, addr 0x8000_0000 -> ok=0.
  - Set pmpcfg0[7:0] = 0x18 (lock cleared) -> ok=1.
- MPRV:
  - Unmatched addr, prv=M, mprv=1, mpp=U, acc=R -> ok=0.
  - Same with acc=X -> ok=1.
  - Matched R-permitted entry with acc=R -> ok=1.
- TOR boundary:
  - pmpaddr[0] = 0x2000_0400, pmpcfg0[7:0] = 0x09, prv=U, acc=R.
  - addr 0x8000_0FFC -> ok=1.
  - addr 0x8000_1000 -> ok=0.
  - addr 0x0 -> ok=1.
- Priority and reset:
  - Entry 0 NAPOT with no permissions, entry 1 overlapping with RWX, prv=S, acc=R -> ok=0.
  - Assert rst -> ok=0 at the following edge.

Source files
------------

// File: rtl/pmp_pkg.sv
// Shared types and encodings for the PMP checker and its per-entry matcher.
package pmp_pkg;

  typedef logic [63:0] word64;

  localparam int pmpaddrbits = 54;

  typedef logic [pmpaddrbits:0] pmpaddr_type;
  typedef pmpaddr_type [15:0] pmpaddr_vec_type;

  typedef enum logic [1:0] {
    A_OFF   = 2'b00,
    A_TOR   = 2'b01,
    A_NA4   = 2'b10,
    A_NAPOT = 2'b11
  } amode_e;

  typedef enum logic [1:0] {
    PRV_U = 2'b00,
    PRV_S = 2'b01,
    PRV_M = 2'b11
  } priv_e;

  localparam logic [1:0] ACC_X = 2'b00;
  localparam logic [1:0] ACC_R = 2'b01;
  localparam logic [1:0] ACC_W = 2'b11;

endpackage

// File: rtl/pmp_entry_match.sv
// Address match and permission extraction for a single PMP entry.
module pmp_entry_match
  import pmp_pkg::*;
#(
  parameter int pmp_g      = 10,
  parameter bit pmp_no_tor = 1'b0,
  parameter bit first      = 1'b0
) (
  input  logic [pmpaddrbits-1:0] addr_i,
  input  logic [pmpaddrbits-1:0] p_i,
  input  logic [pmpaddrbits-1:0] p_prev_i,
  input  logic [7:0]             cfg_i,
  output logic                   match_o,
  output logic                   r_o,
  output logic                   w_o,
  output logic                   x_o,
  output logic                   l_o
);

  localparam logic [pmpaddrbits-1:0] GMASK = {pmpaddrbits{1'b1}} << pmp_g;
  localparam logic [pmpaddrbits-1:0] FORCE =
    (pmp_g >= 2) ? ({pmpaddrbits{1'b1}} >> (pmpaddrbits - (pmp_g - 1))) : '0;

  logic [pmpaddrbits-1:0] lo;
  logic [pmpaddrbits-1:0] pn;
  logic [pmpaddrbits-1:0] lowMask;
  logic                   torMatch;
  logic                   napotMatch;
  logic                   na4Match;
  logic                   unused_cfg;

  assign lo       = first ? '0 : p_prev_i;
  assign torMatch = ((lo & GMASK) <= (addr_i & GMASK)) &&
                    ((addr_i & GMASK) < (p_i & GMASK));

  // pn ^ (pn+1) sets every bit from 0 up to and including the lowest zero of pn.
  assign pn         = p_i | FORCE;
  assign lowMask    = pn ^ (pn + 1'b1);
  assign napotMatch = ((addr_i ^ pn) & ~lowMask) == '0;
  assign na4Match   = (pmp_g == 0) ? (addr_i == p_i) : napotMatch;

  always_comb begin
    match_o = 1'b0;
    case (amode_e'(cfg_i[4:3]))
      A_TOR:   match_o = pmp_no_tor ? 1'b0 : torMatch;
      A_NA4:   match_o = na4Match;
      A_NAPOT: match_o = napotMatch;
      default: match_o = 1'b0;
    endcase
  end

  assign r_o        = cfg_i[0];
  assign w_o        = cfg_i[1];
  assign x_o        = cfg_i[2];
  assign l_o        = cfg_i[7];
  assign unused_cfg = ^cfg_i[6:5];

endmodule

// File: rtl/pmp_checker.sv
// RISC-V PMP checker: matches one access per cycle against up to 16 entries, registered grant.
module pmp_checker
  import pmp_pkg::*;
#(
  parameter bit pmp_check   = 1'b1,
  parameter bit pmp_no_tor  = 1'b0,
  parameter int pmp_entries = 16,
  parameter int pmp_g       = 10,
  parameter int pmp_msb     = 55
) (
  input  logic            clk300p,
  input  logic            rst,
  input  pmpaddr_vec_type pmpaddr,
  input  logic [63:0]     pmpcfg0,
  input  logic [63:0]     pmpcfg2,
  input  logic [pmp_msb:0] address,
  input  logic [1:0]      acc,
  input  logic [1:0]      prv,
  input  logic            mprv,
  input  logic [1:0]      mpp,
  input  logic            valid,
  output logic            ok
);

  logic [15:0] matchVec;
  logic [15:0] rVec;
  logic [15:0] wVec;
  logic [15:0] xVec;
  logic [15:0] lVec;

  for (genvar i = 0; i < 16; i++) begin : gEntry
    logic [7:0] cfgByte;
    if (i < 8) begin : gLo
      assign cfgByte = pmpcfg0[8*i +: 8];
    end else begin : gHi
      assign cfgByte = pmpcfg2[8*(i-8) +: 8];
    end

    if (i < pmp_entries) begin : gImpl
      pmp_entry_match #(
        .pmp_g      (pmp_g),
        .pmp_no_tor (pmp_no_tor),
        .first      (i == 0)
      ) uMatch (
        .addr_i   (address[pmp_msb:2]),
        .p_i      (pmpaddr[i][pmpaddrbits-1:0]),
        .p_prev_i (pmpaddr[(i == 0) ? 0 : i-1][pmpaddrbits-1:0]),
        .cfg_i    (cfgByte),
        .match_o  (matchVec[i]),
        .r_o      (rVec[i]),
        .w_o      (wVec[i]),
        .x_o      (xVec[i]),
        .l_o      (lVec[i])
      );
    end else begin : gNone
      logic unused_byte;
      assign unused_byte = ^cfgByte;
      assign matchVec[i] = 1'b0;
      assign rVec[i]     = 1'b0;
      assign wVec[i]     = 1'b0;
      assign xVec[i]     = 1'b0;
      assign lVec[i]     = 1'b0;
    end
  end

  logic [1:0] effPriv;
  logic       anyMatch;
  logic       winR;
  logic       winW;
  logic       winX;
  logic       winL;
  logic       perm;
  logic       grant;
  logic       ok_d;
  logic       ok_q;
  logic       unused_carry;

  assign effPriv = (mprv && (prv == PRV_M) && (acc != ACC_X)) ? mpp : prv;

  // Scan from the top down so the lowest-index match is the last one written.
  always_comb begin
    anyMatch = 1'b0;
    winR     = 1'b0;
    winW     = 1'b0;
    winX     = 1'b0;
    winL     = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (matchVec[i]) begin
        anyMatch = 1'b1;
        winR     = rVec[i];
        winW     = wVec[i];
        winX     = xVec[i];
        winL     = lVec[i];
      end
    end
  end

  always_comb begin
    case (acc)
      ACC_X:   perm = winX;
      ACC_W:   perm = winW;
      default: perm = winR;
    endcase
  end

  always_comb begin
    grant = 1'b0;
    if (!pmp_check) begin
      grant = 1'b1;
    end else if (anyMatch) begin
      grant = winL ? perm : ((effPriv == PRV_M) || perm);
    end else begin
      grant = (effPriv == PRV_M);
    end
  end

  assign ok_d = !valid || grant;

  always_ff @(posedge clk300p) begin
    if (rst) begin
      ok_q <= 1'b0;
    end else begin
      ok_q <= ok_d;
    end
  end

  assign ok = ok_q;

  always_comb begin
    unused_carry = ^address[1:0];
    for (int i = 0; i < 16; i++) begin
      unused_carry = unused_carry ^ pmpaddr[i][pmpaddrbits];
    end
  end

endmodule

// File: tb/tb_pmp_checker.sv
// Directed scoreboard bench for pmp_checker: expected grants queued at drive time, checked one edge later.
module tb_pmp_checker;
  import pmp_pkg::*;

  logic            clk300p;
  logic            rst;
  pmpaddr_vec_type pmpaddr;
  logic [63:0]     pmpcfg0;
  logic [63:0]     pmpcfg2;
  logic [55:0]     address;
  logic [1:0]      acc;
  logic [1:0]      prv;
  logic            mprv;
  logic [1:0]      mpp;
  logic            valid;
  logic            ok;

  typedef struct {
    logic  exp;
    string tag;
  } sbEntry_t;

  sbEntry_t sbQueue[$];
  int       testCount;
  int       failCount;

  pmp_checker dut (
    .clk300p (clk300p),
    .rst     (rst),
    .pmpaddr (pmpaddr),
    .pmpcfg0 (pmpcfg0),
    .pmpcfg2 (pmpcfg2),
    .address (address),
    .acc     (acc),
    .prv     (prv),
    .mprv    (mprv),
    .mpp     (mpp),
    .valid   (valid),
    .ok      (ok)
  );

  initial clk300p = 1'b0;
  always #5 clk300p = ~clk300p;

  task automatic checkOutput();
    sbEntry_t e;
    testCount++;
    if (sbQueue.size() == 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard_empty: ok=%b required=none", ok);
    end else begin
      e = sbQueue.pop_front();
      assert (ok === e.exp) else begin
        failCount++;
        $error("[TB] FAIL %s: ok=%b required=%b", e.tag, ok, e.exp);
      end
    end
  endtask

  task automatic applyStimulus(input logic [55:0] a, input logic [1:0] ac,
                               input logic [1:0] pv, input logic mp,
                               input logic [1:0] pp, input logic v,
                               input logic e, input string tag);
    sbEntry_t s;
    address = a;
    acc     = ac;
    prv     = pv;
    mprv    = mp;
    mpp     = pp;
    valid   = v;
    s.exp   = e;
    s.tag   = tag;
    sbQueue.push_back(s);
    @(posedge clk300p);
    #1;
    checkOutput();
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    rst       = 1'b1;
    pmpaddr   = '0;
    pmpcfg0   = '0;
    pmpcfg2   = '0;
    address   = '0;
    acc       = ACC_R;
    prv       = PRV_U;
    mprv      = 1'b0;
    mpp       = PRV_U;
    valid     = 1'b0;

    applyStimulus(56'h0, ACC_R, PRV_U, 1'b0, PRV_U, 1'b0, 1'b0, "reset_a");
    applyStimulus(56'h0, ACC_R, PRV_M, 1'b0, PRV_U, 1'b1, 1'b0, "reset_b");
    rst = 1'b0;

    // NAPOT region 0x8000_0000..0x8000_1FFF with R/W only.
    pmpaddr[0] = 55'h2000_03FF;
    pmpcfg0    = 64'h1B;
    applyStimulus(56'h8000_1000, ACC_R, PRV_U, 1'b0, PRV_U, 1'b1, 1'b1, "napot_u_r");
    applyStimulus(56'h8000_1000, ACC_X, PRV_U, 1'b0, PRV_U, 1'b1, 1'b0, "napot_u_x");
    applyStimulus(56'h8000_1FFC, ACC_W, PRV_U, 1'b0, PRV_U, 1'b1, 1'b1, "napot_u_w_top");
    applyStimulus(56'h8000_2000, ACC_R, PRV_U, 1'b0, PRV_U, 1'b1, 1'b0, "nomatch_u");
    applyStimulus(56'h8000_2000, ACC_R, PRV_M, 1'b0, PRV_U, 1'b1, 1'b1, "nomatch_m");
    applyStimulus(56'h8000_2000, ACC_R, PRV_U, 1'b0, PRV_U, 1'b0, 1'b1, "invalid_u");

    pmpcfg0 = 64'h98;
    applyStimulus(56'h8000_0000, ACC_R, PRV_M, 1'b0, PRV_U, 1'b1, 1'b0, "locked_m");
    pmpcfg0 = 64'h18;
    applyStimulus(56'h8000_0000, ACC_R, PRV_M, 1'b0, PRV_U, 1'b1, 1'b1, "unlocked_m");
    applyStimulus(56'h8000_0000, ACC_R, PRV_U, 1'b0, PRV_U, 1'b1, 1'b0, "unlocked_u");

    pmpcfg0 = 64'h1B;
    applyStimulus(56'h8000_2000, ACC_R, PRV_M, 1'b1, PRV_U, 1'b1, 1'b0, "mprv_nomatch_r");
    applyStimulus(56'h8000_2000, ACC_X, PRV_M, 1'b1, PRV_U, 1'b1, 1'b1, "mprv_nomatch_x");
    applyStimulus(56'h8000_1000, ACC_R, PRV_M, 1'b1, PRV_U, 1'b1, 1'b1, "mprv_match_r");
    applyStimulus(56'h8000_1000, ACC_X, PRV_S, 1'b1, PRV_M, 1'b1, 1'b0, "mprv_not_m");

    // TOR from 0 up to 0x8000_1000 (exclusive), read only.
    pmpaddr[0] = 55'h2000_0400;
    pmpcfg0    = 64'h09;
    applyStimulus(56'h8000_0FFC, ACC_R, PRV_U, 1'b0, PRV_U, 1'b1, 1'b1, "tor_below_top");
    applyStimulus(56'h8000_1000, ACC_R, PRV_U, 1'b0, PRV_U, 1'b1, 1'b0, "tor_at_top");
    applyStimulus(56'h0,         ACC_R, PRV_U, 1'b0, PRV_U, 1'b1, 1'b1, "tor_zero");

    // TOR on entry 1 bounded below by entry 0 address.
    pmpaddr[1] = 55'h2000_0800;
    pmpcfg0    = 64'h0900;
    applyStimulus(56'h8000_1000, ACC_R, PRV_U, 1'b0, PRV_U, 1'b1, 1'b1, "tor1_lo");
    applyStimulus(56'h8000_0FFC, ACC_R, PRV_U, 1'b0, PRV_U, 1'b1, 1'b0, "tor1_below");

    // Overlapping entries: entry 0 (no perms) must win over entry 1 (RWX).
    pmpaddr[0] = 55'h2000_03FF;
    pmpaddr[1] = 55'h2000_03FF;
    pmpcfg0    = 64'h1F18;
    applyStimulus(56'h8000_1000, ACC_R, PRV_S, 1'b0, PRV_U, 1'b1, 1'b0, "priority_e0");
    pmpcfg0 = 64'h1F00;
    applyStimulus(56'h8000_1000, ACC_R, PRV_S, 1'b0, PRV_U, 1'b1, 1'b1, "priority_e1");

    rst = 1'b1;
    applyStimulus(56'h8000_1000, ACC_R, PRV_S, 1'b0, PRV_U, 1'b1, 1'b0, "reset_again");
    rst = 1'b0;
    applyStimulus(56'h8000_1000, ACC_R, PRV_S, 1'b0, PRV_U, 1'b1, 1'b1, "after_reset");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
